pipe_stage_buf: RTL and testbench

//  Generic inter-stage pipeline register for the CPU datapath. Replaces the fixed
//  per-stage registers. Uses an elastic valid/ready handshake with an optional
//  2-entry skid, so upstream ready is a register output.
//  A synchronous flush inserts a bubble: valid=0 and the payload equals BUBBLE.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/pipe_stage_buf.sv | 101 ++++++++++
 tb/tb_pipe_stage_buf.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared datapath types for the inter-stage pipeline registers.
// The stage bundles are packed into the WIDTH payload of pipe_stage_buf.
package pipe_pkg;

  typedef enum logic [1:0] {
    UPD_HOLD  = 2'b00,
    UPD_LOAD  = 2'b01,
    UPD_FLUSH = 2'b10
  } upd_e;

  localparam logic [31:0] NOP_INST  = 32'h0000_0001;
  localparam logic [31:0] PC_BUBBLE = 32'hffff_fffc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fd_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } de_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
  } ew_t;

  // Bubble payload for the F/D register: a NOP at an impossible PC.
  function automatic fd_t fd_bubble();
    fd_t b;
    b.pc   = PC_BUBBLE;
    b.inst = NOP_INST;
    return b;
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register with an optional skid entry and a
// synchronous flush that turns the stage into a bubble.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             m_valid, s_valid;
  logic [WIDTH-1:0] m_data, s_data;

  logic             emit, accept;
  logic             s_load, s_clear;
  upd_e             m_upd;
  logic             m_next_valid;
  logic [WIDTH-1:0] m_next_data;

  // With the skid, upstream ready depends only on state; without it, a
  // full stage can still accept when the downstream drains it this cycle.
  assign in_ready = SKID ? ~s_valid : (~m_valid | out_ready);

  assign emit   = m_valid & out_ready;
  // NOTE: flush masks accept so an offered beat is dropped, not half-loaded.
  assign accept = in_valid & in_ready & ~flush;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    m_upd        = UPD_HOLD;
    m_next_valid = m_valid;
    m_next_data  = m_data;
    if (flush) begin
      m_upd = UPD_FLUSH;
    end else if (!m_valid || emit) begin
      m_upd = UPD_LOAD;
      if (s_valid) begin
        m_next_valid = 1'b1;
        m_next_data  = s_data;
      end else if (accept) begin
        m_next_valid = 1'b1;
        m_next_data  = in_data;
      end else begin
        m_next_valid = 1'b0;
        m_next_data  = BUBBLE;
      end
    end
  end

  // S fills only when M is stalled; it drains into M on the next emit.
  assign s_load  = SKID && m_valid && !emit && accept;
  assign s_clear = flush || (s_valid && emit);

  // NOTE: payload registers are reset too, so out_data is BUBBLE (never X) from reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= BUBBLE;
    end else begin
      case (m_upd)
        UPD_FLUSH: begin
          m_valid <= 1'b0;
          m_data  <= BUBBLE;
        end
        UPD_LOAD: begin
          m_valid <= m_next_valid;
          m_data  <= m_next_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_valid <= 1'b0;
      s_data  <= BUBBLE;
    end else if (s_clear) begin
      s_valid <= 1'b0;
    end else if (s_load) begin
      s_valid <= 1'b1;
      s_data  <= in_data;
    end
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign count     = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a SKID=1 F/D-style instance (BUBBLE=NOP)
// and a SKID=0 instance, checked against hand-computed values.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;

  logic        flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  count;

  logic        flush0, in_valid0, out_ready0;
  logic [31:0] in_data0;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [1:0]  count0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(32), .BUBBLE(NOP_INST), .SKID(1'b1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_stage_buf #(.WIDTH(32), .BUBBLE(32'h0), .SKID(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .count(count0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_data0 = '0;
    step();
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h1);
    check("rst_count", {30'b0, count}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    rstn = 1'b1;
    step();

    // Streaming: one beat per cycle, one cycle of latency, count stays 1.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h10 + 32'(i);
      step();
      check("stream_valid", {31'b0, out_valid}, 32'h1);
      check("stream_data", out_data, 32'h10 + 32'(i));
      check("stream_count", {30'b0, count}, 32'h1);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'b0, out_valid}, 32'h0);
    check("drain_bubble", out_data, 32'h1);
    check("drain_count", {30'b0, count}, 32'h0);

    // Asynchronous reset mid-stream, no edge needed.
    in_valid = 1'b1; in_data = 32'h20;
    step();
    check("pre_rst_data", out_data, 32'h20);
    #2 rstn = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'h0);
    check("arst_count", {30'b0, count}, 32'h0);
    check("arst_out_data", out_data, 32'h1);
    in_valid = 1'b0;
    #1 rstn = 1'b1;
    #1;
    check("arst_in_ready", {31'b0, in_ready}, 32'h1);
    step();

    // Backpressure: A to M, B to S, C held off.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA0;
    step();
    check("bp_count1", {30'b0, count}, 32'h1);
    check("bp_ready1", {31'b0, in_ready}, 32'h1);
    in_data = 32'hB0;
    step();
    check("bp_count2", {30'b0, count}, 32'h2);
    check("bp_ready0", {31'b0, in_ready}, 32'h0);
    in_data = 32'hC0;
    step();
    check("bp_hold_count", {30'b0, count}, 32'h2);
    check("bp_hold_data", out_data, 32'hA0);
    out_ready = 1'b1;
    step();
    check("bp_out_b", out_data, 32'hB0);
    check("bp_out_b_count", {30'b0, count}, 32'h1);
    check("bp_ready_back", {31'b0, in_ready}, 32'h1);
    step();
    check("bp_out_c", out_data, 32'hC0);
    check("bp_out_c_valid", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    step();
    check("bp_empty", {31'b0, out_valid}, 32'h0);

    // Flush at count=2 with D offered.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA1;
    step();
    in_data = 32'hB1;
    step();
    check("fl_pre_count", {30'b0, count}, 32'h2);
    flush = 1'b1; in_data = 32'hD1;
    step();
    check("fl_out_valid", {31'b0, out_valid}, 32'h0);
    check("fl_out_data", out_data, 32'h1);
    check("fl_count", {30'b0, count}, 32'h0);
    check("fl_in_ready", {31'b0, in_ready}, 32'h1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("fl_no_d", {31'b0, out_valid}, 32'h0);

    // Flush and emit in the same cycle: A delivered, B dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA2;
    step();
    in_data = 32'hB2;
    step();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    #1;
    check("fe_emit_valid", {31'b0, out_valid}, 32'h1);
    check("fe_emit_data", out_data, 32'hA2);
    step();
    check("fe_count", {30'b0, count}, 32'h0);
    check("fe_valid", {31'b0, out_valid}, 32'h0);
    flush = 1'b0;
    step();
    check("fe_b_dropped", {31'b0, out_valid}, 32'h0);

    // SKID=0: in_ready follows out_ready combinationally when full.
    in_valid0 = 1'b1; in_data0 = 32'h30; out_ready0 = 1'b0;
    step();
    check("s0_count", {30'b0, count0}, 32'h1);
    check("s0_ready_low", {31'b0, in_ready0}, 32'h0);
    out_ready0 = 1'b1;
    #1;
    check("s0_ready_high", {31'b0, in_ready0}, 32'h1);
    out_ready0 = 1'b0;
    #1;
    check("s0_ready_low2", {31'b0, in_ready0}, 32'h0);
    out_ready0 = 1'b1; in_data0 = 32'h31;
    step();
    check("s0_reload_valid", {31'b0, out_valid0}, 32'h1);
    check("s0_reload_data", out_data0, 32'h31);
    out_ready0 = 1'b0; in_data0 = 32'h32;
    step();
    check("s0_max_count", {30'b0, count0}, 32'h1);
    check("s0_held_data", out_data0, 32'h31);
    flush0 = 1'b1;
    step();
    check("s0_flush_valid", {31'b0, out_valid0}, 32'h0);
    check("s0_flush_data", out_data0, 32'h0);
    flush0 = 1'b0; in_valid0 = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
